// File: rtl/hour_disp_pkg.sv
// Shared constants, BCD/7-segment tables and hour-mapping helper for the hour display driver.
package hour_disp_pkg;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 2;

  localparam logic [CNT_W-1:0] HOUR_MAX = 4'd11;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  // gfedcba, active-high, digits 0..9
  localparam logic [SEG_W-1:0] SEG_TABLE [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  typedef struct packed {
    logic [CNT_W-1:0] tens;
    logic [CNT_W-1:0] ones;
  } hour_bcd_t;

  // Count 0 reads as 12 on a 12-hour face.
  function automatic hour_bcd_t hour_to_bcd(input logic [CNT_W-1:0] h);
    hour_bcd_t r;
    if (h == 4'd0) begin
      r.tens = 4'd1;
      r.ones = 4'd2;
    end else if (h <= 4'd9) begin
      r.tens = 4'd0;
      r.ones = h;
    end else begin
      r.tens = 4'd1;
      r.ones = h - 4'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/hour_display_driver_if.sv
// Count/strobe link from the mod-12 hour counter into the display driver.
interface hour_display_driver_if;
  import hour_disp_pkg::*;

  logic [CNT_W-1:0] cnt_in;
  logic             cnt_valid;

  modport master (output cnt_in, output cnt_valid);
  modport slave  (input  cnt_in, input  cnt_valid);
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decode; codes above 9 decode to blank.
module seg7_decode
  import hour_disp_pkg::*;
(
  input  logic [CNT_W-1:0] bcd,
  output logic [SEG_W-1:0] pattern_c
);

  always_comb begin
    pattern_c = SEG_BLANK;
    if (bcd <= 4'd9) pattern_c = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/hour_display_driver.sv
// Samples the hour count, tracks AM/PM, and scans a two-digit 7-segment display.
// Optional LEADING_BLANK_EN blanks a zero tens digit while it is scanned.
module hour_display_driver
  import hour_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  hour_display_driver_if.slave cnt,
  output logic [CNT_W-1:0]     digit_tens,
  output logic [CNT_W-1:0]     digit_ones,
  output logic                 pm,
  output logic [SEG_W-1:0]     seg,
  output logic [AN_W-1:0]      an,
  output logic                 err
);

  localparam int unsigned REF_W = $clog2(REFRESH_DIV);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] hold;
  logic [REF_W-1:0] ref_cnt;
  logic             legal_c;
  hour_bcd_t        bcd_c;
  logic [CNT_W-1:0] sel_digit_c;
  logic [SEG_W-1:0] pattern_c;

  assign legal_c     = (cnt.cnt_in <= HOUR_MAX);
  assign bcd_c       = hour_to_bcd(cnt.cnt_in);
  assign sel_digit_c = an[1] ? digit_tens : digit_ones;

  // Sample path: hold, displayed digits, AM/PM and sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold       <= 4'd0;
      digit_tens <= 4'd1;
      digit_ones <= 4'd2;
      pm         <= 1'b0;
      err        <= 1'b0;
    end else if (cnt.cnt_valid) begin
      if (legal_c) begin
        hold       <= cnt.cnt_in;
        digit_tens <= bcd_c.tens;
        digit_ones <= bcd_c.ones;
        // Only a genuine 11 -> 0 wrap crosses noon/midnight.
        if ((cnt.cnt_in == 4'd0) && (hold == HOUR_MAX)) pm <= ~pm;
      end else begin
        err <= 1'b1;
      end
    end
  end

  // Digit scan: dwell REFRESH_DIV cycles on each digit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ref_cnt <= '0;
      an      <= 2'b01;
    end else if (ref_cnt == REF_LAST) begin
      ref_cnt <= '0;
      an      <= {an[0], an[1]};
    end else begin
      ref_cnt <= ref_cnt + REF_W'(1);
    end
  end

  seg7_decode u_seg7_decode (
    .bcd       (sel_digit_c),
    .pattern_c (pattern_c)
  );

  // Segment register follows the selected digit one cycle later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      seg <= SEG_TABLE[2];
    end else begin
`ifdef LEADING_BLANK_EN
      if (an[1] && (digit_tens == 4'd0)) seg <= SEG_BLANK;
      else                               seg <= pattern_c;
`else
      seg <= pattern_c;
`endif
    end
  end

endmodule

// File: tb/tb_hour_display_driver.sv
// Directed, table-driven bench for hour_display_driver with a short refresh period.
module tb_hour_display_driver;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] digit_tens, digit_ones;
  logic       pm, err;
  logic [6:0] seg;
  logic [1:0] an;

  int applied = 0;
  int miscompares = 0;

  hour_display_driver_if cnt ();

  hour_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .cnt(cnt),
    .digit_tens(digit_tens), .digit_ones(digit_ones),
    .pm(pm), .seg(seg), .an(an), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cnt_v;
    logic [3:0] exp_tens;
    logic [3:0] exp_ones;
    logic       exp_pm;
    logic       exp_err;
  } vec_t;

  vec_t vecs [13];

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic strobe(input logic [3:0] v);
    cnt.cnt_valid = 1'b1;
    cnt.cnt_in    = v;
    wait_edge();
    cnt.cnt_valid = 1'b0;
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: seg_of = 7'b0111111;
      4'd2: seg_of = 7'b1011011;
      4'd3: seg_of = 7'b1001111;
      default: seg_of = 7'bxxxxxxx;
    endcase
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_tens"}, 8'(digit_tens), 8'd1);
    check({tag, "_ones"}, 8'(digit_ones), 8'd2);
    check({tag, "_pm"},   8'(pm),         8'd0);
    check({tag, "_an"},   8'(an),         8'd1);
    check({tag, "_err"},  8'(err),        8'd0);
    check({tag, "_seg"},  8'(seg),        8'h5B);
  endtask

  initial begin
    logic [1:0] an_m;
    logic [3:0] t_m, o_m;
    logic [6:0] seg_exp;
    int         guard;

    vecs[0]  = '{4'd10, 4'd1, 4'd0, 1'b0, 1'b0};
    vecs[1]  = '{4'd11, 4'd1, 4'd1, 1'b0, 1'b0};
    vecs[2]  = '{4'd0,  4'd1, 4'd2, 1'b1, 1'b0};
    vecs[3]  = '{4'd11, 4'd1, 4'd1, 1'b1, 1'b0};
    vecs[4]  = '{4'd0,  4'd1, 4'd2, 1'b0, 1'b0};
    vecs[5]  = '{4'd7,  4'd0, 4'd7, 1'b0, 1'b0};
    vecs[6]  = '{4'd13, 4'd0, 4'd7, 1'b0, 1'b1};
    vecs[7]  = '{4'd3,  4'd0, 4'd3, 1'b0, 1'b1};
    vecs[8]  = '{4'd5,  4'd0, 4'd5, 1'b0, 1'b1};
    vecs[9]  = '{4'd0,  4'd1, 4'd2, 1'b0, 1'b1};
    vecs[10] = '{4'd0,  4'd1, 4'd2, 1'b0, 1'b1};
    vecs[11] = '{4'd9,  4'd0, 4'd9, 1'b0, 1'b1};
    vecs[12] = '{4'd15, 4'd0, 4'd9, 1'b0, 1'b1};

    cnt.cnt_valid = 1'b0;
    cnt.cnt_in    = 4'd0;

    // Power-on reset: two cycles low.
    rst = 1'b0;
    wait_edge();
    wait_edge();
    rst = 1'b1;
    check_reset_values("reset");

    foreach (vecs[i]) begin
      strobe(vecs[i].cnt_v);
      check($sformatf("vec%0d_tens", i), 8'(digit_tens), 8'(vecs[i].exp_tens));
      check($sformatf("vec%0d_ones", i), 8'(digit_ones), 8'(vecs[i].exp_ones));
      check($sformatf("vec%0d_pm",   i), 8'(pm),         8'(vecs[i].exp_pm));
      check($sformatf("vec%0d_err",  i), 8'(err),        8'(vecs[i].exp_err));
    end

    // Back-to-back strobes 11,0,11,0: pm 0,1,1,0.
    cnt.cnt_valid = 1'b1;
    cnt.cnt_in = 4'd11; wait_edge(); check("b2b_pm0", 8'(pm), 8'd0);
    cnt.cnt_in = 4'd0;  wait_edge(); check("b2b_pm1", 8'(pm), 8'd1);
    cnt.cnt_in = 4'd11; wait_edge(); check("b2b_pm2", 8'(pm), 8'd1);
    cnt.cnt_in = 4'd0;  wait_edge(); check("b2b_pm3", 8'(pm), 8'd0);
    cnt.cnt_valid = 1'b0;

    // Scan: reset, then load 3 right at release and follow an/seg for 3 dwells.
    rst = 1'b0;
    wait_edge();
    wait_edge();
    rst = 1'b1;
    cnt.cnt_valid = 1'b1;
    cnt.cnt_in    = 4'd3;
    an_m = 2'b01; t_m = 4'd1; o_m = 4'd2;
    for (int k = 1; k <= 12; k++) begin
      wait_edge();
      if (k == 1) cnt.cnt_valid = 1'b0;
      if (an_m == 2'b01) seg_exp = seg_of(o_m);
`ifdef LEADING_BLANK_EN
      else if (t_m == 4'd0) seg_exp = 7'b0000000;
`endif
      else seg_exp = seg_of(t_m);
      an_m = ((k / 4) % 2 == 1) ? 2'b10 : 2'b01;
      t_m = 4'd0; o_m = 4'd3;
      check($sformatf("scan%0d_an", k),  8'(an),  8'(an_m));
      check($sformatf("scan%0d_seg", k), 8'(seg), 8'(seg_exp));
    end

    // Mid-operation reset with a coincident strobe of 11.
    strobe(4'd11);
    strobe(4'd0);
    strobe(4'd13);
    check("pre_pm",  8'(pm),  8'd1);
    check("pre_err", 8'(err), 8'd1);
    guard = 0;
    while (an != 2'b10 && guard < 20) begin
      wait_edge();
      guard++;
    end
    check("pre_an", 8'(an), 8'd2);
    rst = 1'b0;
    cnt.cnt_valid = 1'b1;
    cnt.cnt_in    = 4'd11;
    wait_edge();
    rst = 1'b1;
    cnt.cnt_valid = 1'b0;
    check_reset_values("midrst");
    wait_edge(); wait_edge(); wait_edge();
    check("dwell_an3", 8'(an), 8'd1);
    wait_edge();
    check("dwell_an4", 8'(an), 8'd2);
    strobe(4'd0);
    check("drop_pm",   8'(pm),         8'd0);
    check("drop_tens", 8'(digit_tens), 8'd1);
    check("drop_ones", 8'(digit_ones), 8'd2);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
